// File: rtl/alsu_pkg.sv
// alsu_pkg: opcodes, cmd_data field offsets and issuer FSM states
package alsu_pkg;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_XOR = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_DIV = 3'b101;
  localparam int OFF_OPCODE = 0;
  localparam int OFF_RED_A  = 3;
  localparam int OFF_RED_B  = 4;
  localparam int OFF_BYP_A  = 5;
  localparam int OFF_BYP_B  = 6;
  localparam int OFF_CIN    = 7;
  localparam int OFF_A      = 8;
  function automatic int off_b(input int width);
    return OFF_A + width;
  endfunction
  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;
endpackage

// File: rtl/alsu_cmd_unpack.sv
// alsu_cmd_unpack: slices a packed command word into ALSU fields
import alsu_pkg::*;
module alsu_cmd_unpack #(
  parameter int WIDTH = 4
) (
  input  logic [2*WIDTH+7:0] cmd_data,
  output logic [2:0]         opcode,
  output logic               red_op_a,
  output logic               red_op_b,
  output logic               bypass_a,
  output logic               bypass_b,
  output logic               cin,
  output logic [WIDTH-1:0]   a,
  output logic [WIDTH-1:0]   b
);
  assign opcode   = cmd_data[OFF_OPCODE +: 3];
  assign red_op_a = cmd_data[OFF_RED_A];
  assign red_op_b = cmd_data[OFF_RED_B];
  assign bypass_a = cmd_data[OFF_BYP_A];
  assign bypass_b = cmd_data[OFF_BYP_B];
  assign cin      = cmd_data[OFF_CIN];
  assign a        = cmd_data[OFF_A +: WIDTH];
  assign b        = cmd_data[off_b(WIDTH) +: WIDTH];
endmodule

// File: rtl/alsu_cmd_issuer.sv
// alsu_cmd_issuer: issues one command to an ALSU, captures its result and hands it on
import alsu_pkg::*;
module alsu_cmd_issuer #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2*WIDTH+7:0]   cmd_data,
  output logic [WIDTH-1:0]     alu_A,
  output logic [WIDTH-1:0]     alu_B,
  output logic [2:0]           alu_Opcode,
  output logic                 alu_Cin,
  output logic                 alu_red_op_A,
  output logic                 alu_red_op_B,
  output logic                 alu_bypass_A,
  output logic                 alu_bypass_B,
  input  logic [2*WIDTH-1:0]   alu_out,
  input  logic                 alu_Odd_parity,
  input  logic                 alu_Invalid,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [2*WIDTH+1:0]   rsp_data,
  input  logic                 cnt_clr,
  output logic [7:0]           invalid_cnt,
  output logic                 busy
);
  state_t state_q, state_d;
  logic [2:0] u_opcode;
  logic u_red_a, u_red_b, u_byp_a, u_byp_b, u_cin;
  logic [WIDTH-1:0] u_a, u_b;
  logic accept, rsp_hs;

  alsu_cmd_unpack #(.WIDTH(WIDTH)) u_unpack (
    .cmd_data (cmd_data),
    .opcode   (u_opcode),
    .red_op_a (u_red_a),
    .red_op_b (u_red_b),
    .bypass_a (u_byp_a),
    .bypass_b (u_byp_b),
    .cin      (u_cin),
    .a        (u_a),
    .b        (u_b)
  );

  assign cmd_ready = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign rsp_valid = state_q == RESP;
  assign accept    = cmd_valid && cmd_ready;
  assign rsp_hs    = rsp_valid && rsp_ready;

  // Next state: accept in IDLE, single-cycle DRIVE, hold RESP until handshake
  always_comb begin
    state_d = state_q;
    state_d = accept ? DRIVE : (state_q == DRIVE) ? RESP : rsp_hs ? IDLE : state_q;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;

  // ALSU operand/control registers, loaded only on accept and held otherwise
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      alu_A        <= '0;
      alu_B        <= '0;
      alu_Opcode   <= '0;
      alu_Cin      <= 1'b0;
      alu_red_op_A <= 1'b0;
      alu_red_op_B <= 1'b0;
      alu_bypass_A <= 1'b0;
      alu_bypass_B <= 1'b0;
    end else if (accept) begin
      alu_A        <= u_a;
      alu_B        <= u_b;
      alu_Opcode   <= u_opcode;
      alu_Cin      <= u_cin;
      alu_red_op_A <= u_red_a;
      alu_red_op_B <= u_red_b;
      alu_bypass_A <= u_byp_a;
      alu_bypass_B <= u_byp_b;
    end

  // Response capture at the closing edge of DRIVE
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rsp_data <= '0;
    else if (state_q == DRIVE) rsp_data <= {alu_Invalid, alu_Odd_parity, alu_out};

  // Saturating count of handed-off invalid responses; clear has priority
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) invalid_cnt <= '0;
    else if (cnt_clr) invalid_cnt <= '0;
    else if (rsp_hs && rsp_data[2*WIDTH+1] && invalid_cnt != 8'hFF) invalid_cnt <= invalid_cnt + 8'd1;
endmodule

// File: tb/tb_alsu_cmd_issuer.sv
// tb_alsu_cmd_issuer: directed checks of the issuer against a behavioural ALSU
module tb_alsu_cmd_issuer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [15:0] cmd_data = '0;
  logic [3:0] alu_A, alu_B;
  logic [2:0] alu_Opcode;
  logic alu_Cin, alu_red_op_A, alu_red_op_B, alu_bypass_A, alu_bypass_B;
  logic [7:0] alu_out;
  logic alu_Odd_parity, alu_Invalid;
  logic rsp_valid;
  logic rsp_ready = 1'b1;
  logic [9:0] rsp_data;
  logic cnt_clr = 1'b0;
  logic [7:0] invalid_cnt;
  logic busy;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alsu_cmd_issuer #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .alu_A(alu_A), .alu_B(alu_B), .alu_Opcode(alu_Opcode), .alu_Cin(alu_Cin),
    .alu_red_op_A(alu_red_op_A), .alu_red_op_B(alu_red_op_B),
    .alu_bypass_A(alu_bypass_A), .alu_bypass_B(alu_bypass_B),
    .alu_out(alu_out), .alu_Odd_parity(alu_Odd_parity), .alu_Invalid(alu_Invalid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .cnt_clr(cnt_clr), .invalid_cnt(invalid_cnt), .busy(busy)
  );

  function automatic logic [9:0] alsu_model(input logic [2:0] op, input logic ra, rb, ba, bb, ci,
                                            input logic [3:0] a, b);
    logic [7:0] o;
    logic inv;
    inv = op > 3'd5 || ((ra || rb) && op > 3'd1) || (ra && rb) || (op == 3'd5 && b == 4'd0);
    case (op)
      3'd0: o = ra ? {7'd0, &a} : rb ? {7'd0, &b} : {4'd0, a & b};
      3'd1: o = ra ? {7'd0, ^a} : rb ? {7'd0, ^b} : {4'd0, a ^ b};
      3'd2: o = {4'd0, a} + {4'd0, b} + {7'd0, ci};
      3'd3: o = {4'd0, a} * {4'd0, b};
      3'd4: o = {4'd0, a} - {4'd0, b};
      3'd5: o = (b == 4'd0) ? 8'hFF : {4'd0, a / b};
      default: o = 8'd0;
    endcase
    if (ba) o = {4'd0, a};
    else if (bb) o = {4'd0, b};
    return {inv, ~^o, o};
  endfunction

  assign {alu_Invalid, alu_Odd_parity, alu_out} = alsu_model(alu_Opcode, alu_red_op_A, alu_red_op_B,
                                                             alu_bypass_A, alu_bypass_B, alu_Cin, alu_A, alu_B);

  function automatic logic [15:0] cmd(input logic [2:0] op, input logic ra, rb, ba, bb, ci,
                                      input logic [3:0] a, b);
    return {b, a, ci, bb, ba, rb, ra, op};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick();
    check("rst_ready", {31'd0, cmd_ready}, 1);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    check("rst_rsp_data", {22'd0, rsp_data}, 0);
    check("rst_cnt", {24'd0, invalid_cnt}, 0);
    rst_n = 1'b1;
    tick();
    check("idle_ready", {31'd0, cmd_ready}, 1);

    cmd_data = cmd(3'b010, 0, 0, 0, 0, 1, 4'hF, 4'h1);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("add_operands", {17'd0, alu_B, alu_A, alu_Opcode, alu_Cin, alu_red_op_A, alu_red_op_B,
                           alu_bypass_A, alu_bypass_B}, {17'd0, 4'h1, 4'hF, 3'b010, 1'b1, 4'b0000});
    check("add_drive_busy", {30'd0, busy, cmd_ready}, 32'b10);
    check("add_drive_novalid", {31'd0, rsp_valid}, 0);
    tick();
    check("add_rsp_valid", {31'd0, rsp_valid}, 1);
    check("add_rsp_data", {22'd0, rsp_data}, 32'h111);
    tick();
    check("add_back_idle", {30'd0, rsp_valid, cmd_ready}, 32'b01);
    check("add_alu_hold", {28'd0, alu_A}, 32'hF);
    check("add_cnt", {24'd0, invalid_cnt}, 0);

    cmd_data = cmd(3'b000, 1, 1, 0, 0, 0, 4'hF, 4'h0);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("red_rsp_data", {22'd0, rsp_data}, 32'h201);
    check("red_cnt_before", {24'd0, invalid_cnt}, 0);
    tick();
    check("red_cnt_after", {24'd0, invalid_cnt}, 1);

    cmd_data = cmd(3'b101, 0, 0, 0, 0, 0, 4'h3, 4'h0);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("div0_rsp_data", {22'd0, rsp_data}, 32'h3FF);
    tick();
    check("div0_cnt", {24'd0, invalid_cnt}, 2);

    rsp_ready = 1'b0;
    cmd_data = cmd(3'b001, 0, 0, 0, 0, 0, 4'h5, 4'h3);
    cmd_valid = 1'b1;
    tick();
    cmd_data = cmd(3'b000, 0, 0, 0, 0, 0, 4'hC, 4'hA);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_data", {22'd0, rsp_data}, 32'h106);
      check("bp_ready_low", {30'd0, cmd_ready, rsp_valid}, 32'b01);
      check("bp_alu_hold", {28'd0, alu_A}, 32'h5);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    check("bp_handshake_idle", {31'd0, cmd_ready}, 1);
    check("bp_no_early_accept", {28'd0, alu_A}, 32'h5);
    tick();
    cmd_valid = 1'b0;
    check("bp_second_accept", {28'd0, alu_A}, 32'hC);
    tick();
    check("bp_second_rsp", {22'd0, rsp_data}, 32'h008);
    tick();

    cmd_data = cmd(3'b010, 0, 0, 0, 0, 0, 4'h2, 4'h3);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("mid_in_drive", {31'd0, busy}, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_alu", {20'd0, alu_A, alu_B, alu_Opcode, alu_Cin}, 0);
    check("mid_rst_rsp", {21'd0, rsp_valid, rsp_data}, 0);
    check("mid_rst_busy_cnt", {23'd0, busy, invalid_cnt}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("mid_post_ready", {30'd0, cmd_ready, rsp_valid}, 32'b10);

    cmd_data = cmd(3'b111, 0, 0, 0, 0, 0, 4'h1, 4'h1);
    cmd_valid = 1'b1;
    for (int i = 0; i < 3 * 260; i++) tick();
    check("sat_idle", {31'd0, cmd_ready}, 1);
    tick();
    tick();
    check("sat_cnt", {24'd0, invalid_cnt}, 255);
    check("sat_in_resp", {22'd0, rsp_data}, 32'h300);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    cmd_valid = 1'b0;
    check("clr_wins", {24'd0, invalid_cnt}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
